// File: rtl/ascii_text_scroller.sv
// Purpose : message buffer plus scroll sequencer that feeds an ASCII seven-segment display wrapper.
// Latency : every output is registered from next-state, so an accepted event is visible one edge later.
// Backpressure: wr_ready drops while scrolling or when the buffer is full; writes without wr_ready are dropped.
//
// Ports:
//   clk, reset     : system clock and synchronous active-high reset
//   clear          : empty the buffer and return to idle (highest priority after reset)
//   wr_en, wr_char : append one ASCII character per cycle while wr_ready is high
//   wr_ready       : idle and buffer not full
//   start, stop    : begin or halt scrolling (the buffer is kept on stop)
//   busy           : scrolling
//   values         : ASCII per digit, digit k at [8k+7:8k], digit DISPLAY_COUNT-1 is leftmost
//   display_enable : per-digit enable, all ones only while scrolling
module ascii_text_scroller #(
   parameter int DISPLAY_COUNT = 4,
   parameter int SOURCE_FREQ   = 100_000_000,
   parameter int SCROLL_HZ     = 2,
   parameter int MAX_LEN       = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       clear,
   input  logic                       wr_en,
   input  logic [7:0]                 wr_char,
   output logic                       wr_ready,
   input  logic                       start,
   input  logic                       stop,
   output logic                       busy,
   output logic [8*DISPLAY_COUNT-1:0] values,
   output logic [DISPLAY_COUNT-1:0]   display_enable
);

   localparam int DIV    = SOURCE_FREQ / SCROLL_HZ;
   localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int LEN_W  = $clog2(MAX_LEN + 1);
   localparam int POS_W  = $clog2(MAX_LEN + DISPLAY_COUNT);
   // Wide enough for pos + DISPLAY_COUNT-1 before the single wrap subtract.
   localparam int IDX_W  = $clog2(2 * (MAX_LEN + DISPLAY_COUNT));
   localparam int ADDR_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

   typedef enum logic {IDLE, SCROLL} state_t;

   state_t                     state, state_n;
   logic [7:0]                 char_buf [MAX_LEN];
   logic [LEN_W-1:0]           len, len_n;
   logic [POS_W-1:0]           pos, pos_n;
   logic [DIV_W-1:0]           div_cnt, div_n;
   logic                       do_write;
   logic                       tick;
   logic [IDX_W-1:0]           seq_len, seq_len_n;
   logic [IDX_W-1:0]           idx [DISPLAY_COUNT];
   logic [8*DISPLAY_COUNT-1:0] window;

   assign tick      = (div_cnt == DIV_W'(DIV - 1));
   assign seq_len   = IDX_W'(len)   + IDX_W'(DISPLAY_COUNT);
   assign seq_len_n = IDX_W'(len_n) + IDX_W'(DISPLAY_COUNT);

   // Next-state with priority clear > stop > start > tick > write.
   always_comb begin
      state_n  = state;
      len_n    = len;
      pos_n    = pos;
      div_n    = div_cnt;
      do_write = 1'b0;
      if (clear) begin
         state_n = IDLE;
         len_n   = '0;
         pos_n   = '0;
         div_n   = '0;
      end else if (state == SCROLL) begin
         if (stop) begin
            // A tick landing on the same cycle is dropped: pos stays put.
            state_n = IDLE;
            div_n   = '0;
         end else if (tick) begin
            div_n = '0;
            pos_n = (IDX_W'(pos) == seq_len - 1'b1) ? '0 : pos + 1'b1;
         end else begin
            div_n = div_cnt + 1'b1;
         end
      end else if (!stop) begin
         if (start && len != '0) begin
            state_n = SCROLL;
            pos_n   = '0;
            div_n   = '0;
         end else if (wr_en && len < LEN_W'(MAX_LEN)) begin
            do_write = 1'b1;
            len_n    = len + 1'b1;
         end
      end
   end

   // Window from next-state pos/len; positions past len read as space padding.
   always_comb begin
      window = '0;
      for (int k = 0; k < DISPLAY_COUNT; k++) begin
         idx[k] = IDX_W'(pos_n) + IDX_W'(DISPLAY_COUNT - 1 - k);
         if (idx[k] >= seq_len_n)
            idx[k] = idx[k] - seq_len_n;
         window[8*k +: 8] = (idx[k] < IDX_W'(len_n)) ? char_buf[idx[k][ADDR_W-1:0]] : 8'h20;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= IDLE;
         len            <= '0;
         pos            <= '0;
         div_cnt        <= '0;
         wr_ready       <= 1'b1;
         busy           <= 1'b0;
         values         <= {DISPLAY_COUNT{8'h20}};
         display_enable <= '0;
      end else begin
         state          <= state_n;
         len            <= len_n;
         pos            <= pos_n;
         div_cnt        <= div_n;
         wr_ready       <= (state_n == IDLE) && (len_n < LEN_W'(MAX_LEN));
         busy           <= (state_n == SCROLL);
         display_enable <= {DISPLAY_COUNT{state_n == SCROLL}};
         values         <= (state_n == SCROLL) ? window : {DISPLAY_COUNT{8'h20}};
      end
   end

   // Buffer contents are not cleared; len alone defines what is valid.
   always_ff @(posedge clk) begin
      if (!reset && do_write)
         char_buf[len[ADDR_W-1:0]] <= wr_char;
   end

endmodule

// File: tb/tb_ascii_text_scroller.sv
module tb_ascii_text_scroller;

   localparam int DC  = 4;
   localparam int ML  = 8;
   localparam int SF  = 8;
   localparam int SH  = 2;
   localparam int DIV = SF / SH;
   localparam logic [31:0] BLANK = 32'h20202020;

   logic        clk = 1'b0;
   logic        reset, clear, wr_en, start, stop;
   logic [7:0]  wr_char;
   logic        wr_ready, busy;
   logic [31:0] values;
   logic [3:0]  display_enable;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   ascii_text_scroller #(
      .DISPLAY_COUNT(DC), .SOURCE_FREQ(SF), .SCROLL_HZ(SH), .MAX_LEN(ML)
   ) dut (
      .clk(clk), .reset(reset), .clear(clear), .wr_en(wr_en), .wr_char(wr_char),
      .wr_ready(wr_ready), .start(start), .stop(stop), .busy(busy),
      .values(values), .display_enable(display_enable)
   );

   typedef struct {
      logic        rst, clr, we;
      logic [7:0]  ch;
      logic        st, sp;
      logic [31:0] ev;
      logic [3:0]  een;
      logic        ewr, ebusy;
   } vec_t;

   vec_t vq[$];

   function automatic void add(input logic rst, input logic clr, input logic we,
                               input logic [7:0] ch, input logic st, input logic sp,
                               input logic [31:0] ev, input logic ebusy, input logic ewr);
      vec_t v;
      v.rst = rst; v.clr = clr; v.we = we; v.ch = ch; v.st = st; v.sp = sp;
      v.ev = ev; v.ebusy = ebusy; v.ewr = ewr;
      v.een = ebusy ? 4'hF : 4'h0;
      vq.push_back(v);
   endfunction

   // Reference model: a character queue plus a scroll position and elapsed-cycle count.
   byte unsigned mq[$];
   bit           m_scroll;
   int           m_pos;
   int           m_elapsed;

   task automatic model_step(input logic rst, input logic clr, input logic we,
                             input logic [7:0] ch, input logic st, input logic sp);
      if (rst || clr) begin
         mq.delete();
         m_scroll = 0;
         m_pos    = 0;
      end else if (m_scroll) begin
         if (sp) begin
            m_scroll = 0;
         end else begin
            m_elapsed++;
            if (m_elapsed % DIV == 0)
               m_pos = (m_pos + 1) % (mq.size() + DC);
         end
      end else if (!sp) begin
         if (st && mq.size() > 0) begin
            m_scroll  = 1;
            m_pos     = 0;
            m_elapsed = 0;
         end else if (we && mq.size() < ML) begin
            mq.push_back(ch);
         end
      end
   endtask

   function automatic logic [31:0] model_values();
      logic [31:0] r;
      int          L, i;
      r = BLANK;
      if (m_scroll) begin
         L = mq.size() + DC;
         for (int k = 0; k < DC; k++) begin
            i = (m_pos + DC - 1 - k) % L;
            r[8*k +: 8] = (i < mq.size()) ? mq[i] : 8'h20;
         end
      end
      return r;
   endfunction

   logic [31:0] hi [6];
   logic [31:0] ab [6];

   initial begin
      logic [31:0] ev;
      logic        ewr;
      reset = 1'b1; clear = 1'b0; wr_en = 1'b0; wr_char = 8'h00; start = 1'b0; stop = 1'b0;
      m_scroll = 0; m_pos = 0; m_elapsed = 0;

      hi[0] = 32'h48492020; hi[1] = 32'h49202020; hi[2] = 32'h20202020;
      hi[3] = 32'h20202048; hi[4] = 32'h20204849; hi[5] = 32'h20484920;
      ab[0] = 32'h41424344; ab[1] = 32'h42434445; ab[2] = 32'h43444546;
      ab[3] = 32'h44454647; ab[4] = 32'h45464748; ab[5] = 32'h46474820;

      // Reset, then "HI" scrolled through a full period and beyond.
      add(1, 0, 0, 8'h00, 0, 0, BLANK, 0, 1);
      add(1, 0, 0, 8'h00, 0, 0, BLANK, 0, 1);
      add(0, 0, 1, 8'h48, 0, 0, BLANK, 0, 1);
      add(0, 0, 1, 8'h49, 0, 0, BLANK, 0, 1);
      add(0, 0, 0, 8'h00, 1, 0, hi[0], 1, 0);
      for (int j = 1; j <= 27; j++) add(0, 0, 0, 8'h00, 0, 0, hi[(j / 4) % 6], 1, 0);
      // Stop lands on the cycle a tick is due; restart resumes at pos 0.
      add(0, 0, 0, 8'h00, 0, 1, BLANK, 0, 1);
      add(0, 0, 0, 8'h00, 1, 0, hi[0], 1, 0);
      for (int j = 1; j <= 5; j++) add(0, 0, 0, 8'h00, 0, 0, hi[j / 4], 1, 0);
      // Clear beats simultaneous write and start; empty start is ignored.
      add(0, 1, 1, 8'h5A, 1, 0, BLANK, 0, 1);
      add(0, 0, 0, 8'h00, 1, 0, BLANK, 0, 1);
      // Nine back-to-back writes into an 8-deep buffer.
      for (int i = 0; i < 9; i++) begin
         ewr = (i < 7);
         add(0, 0, 1, 8'h41 + 8'(i), 0, 0, BLANK, 0, ewr);
      end
      add(0, 0, 0, 8'h00, 1, 0, ab[0], 1, 0);
      for (int j = 1; j <= 20; j++) add(0, 0, 0, 8'h00, 0, 0, ab[j / 4], 1, 0);
      add(0, 0, 0, 8'h00, 0, 1, BLANK, 0, 0);
      add(0, 0, 0, 8'h00, 1, 0, ab[0], 1, 0);
      for (int j = 1; j <= 13; j++) add(0, 0, 0, 8'h00, 0, 0, ab[j / 4], 1, 0);
      // Reset at pos 3, then a start that must be ignored.
      add(1, 0, 0, 8'h00, 0, 0, BLANK, 0, 1);
      add(0, 0, 0, 8'h00, 1, 0, BLANK, 0, 1);

      foreach (vq[n]) begin
         reset = vq[n].rst; clear = vq[n].clr; wr_en = vq[n].we;
         wr_char = vq[n].ch; start = vq[n].st; stop = vq[n].sp;
         @(posedge clk);
         #1;
         tests++;
         if ({values, display_enable, wr_ready, busy} !==
             {vq[n].ev, vq[n].een, vq[n].ewr, vq[n].ebusy}) begin
            fails++;
            $display("FAIL vec[%0d]: values=%h en=%b wr_ready=%b busy=%b, expected values=%h en=%b wr_ready=%b busy=%b",
                     n, values, display_enable, wr_ready, busy,
                     vq[n].ev, vq[n].een, vq[n].ewr, vq[n].ebusy);
         end
      end

      // Randomised run against the reference model.
      reset = 1'b1; clear = 0; wr_en = 0; start = 0; stop = 0;
      model_step(1, 0, 0, 8'h00, 0, 0);
      @(posedge clk);
      #1;
      for (int c = 0; c < 3000; c++) begin
         reset   = ($urandom_range(0, 999) < 4);
         clear   = ($urandom_range(0, 99) < 2);
         stop    = ($urandom_range(0, 99) < 3);
         start   = ($urandom_range(0, 99) < 10);
         wr_en   = ($urandom_range(0, 1) == 1);
         wr_char = 8'($urandom_range(32, 126));
         model_step(reset, clear, wr_en, wr_char, start, stop);
         @(posedge clk);
         #1;
         ev = model_values();
         tests++;
         if (values !== ev) begin
            fails++;
            $display("FAIL rand values cyc %0d: got %h want %h", c, values, ev);
         end
         tests++;
         if (display_enable !== (m_scroll ? 4'hF : 4'h0)) begin
            fails++;
            $display("FAIL rand enable cyc %0d: got %b want %b", c, display_enable, m_scroll ? 4'hF : 4'h0);
         end
         tests++;
         if (busy !== m_scroll) begin
            fails++;
            $display("FAIL rand busy cyc %0d: got %b want %b", c, busy, m_scroll);
         end
         tests++;
         if (wr_ready !== (!m_scroll && mq.size() < ML)) begin
            fails++;
            $display("FAIL rand wr_ready cyc %0d: got %b want %b", c, wr_ready, (!m_scroll && mq.size() < ML));
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/ascii_text_scroller.md
# ascii_text_scroller

Message buffer and scroll sequencer that sits directly upstream of the ASCII seven-segment display wrapper. It collects a string of 8-bit ASCII characters written one per cycle. On command it scrolls the string right-to-left across `DISPLAY_COUNT` digits at a fixed rate, driving the wrapper's `values` and `display_enable` inputs. Padding between repetitions is ASCII space (0x20).

## Interface

Parameters:
- `DISPLAY_COUNT`, 4: number of digits; matches the downstream wrapper.
- `SOURCE_FREQ`, 100_000_000: input clock frequency in Hz.
- `SCROLL_HZ`, 2: scroll steps per second. `DIV = SOURCE_FREQ / SCROLL_HZ` (integer division, must be ≥ 1).
- `MAX_LEN`, 16: buffer capacity in characters (≥ 1).

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `clear`  in  1  empties the buffer and returns to IDLE.
- `wr_en`  in  1  write strobe; accepted only when `wr_ready` = 1.
- `wr_char`  in  8  ASCII character to append.
- `wr_ready`  out  1  high in IDLE when `len < MAX_LEN`.
- `start`  in  1  begin scrolling.
- `stop`  in  1  halt scrolling; the buffer is retained.
- `busy`  out  1  high in SCROLL.
- `values`  out  8*DISPLAY_COUNT  ASCII per digit; `values[8k+7:8k]` is digit k, and digit `DISPLAY_COUNT-1` is leftmost.
- `display_enable`  out  DISPLAY_COUNT  per-digit enable.

## Operation

- Storage: `buf[0..MAX_LEN-1]` of 8 bits each, plus `len` of width clog2(MAX_LEN+1).
- State machine with two states, IDLE and SCROLL.
- IDLE:
  - `wr_en && wr_ready` writes `wr_char` to `buf[len]`, then `len++`.
  - `wr_en` is ignored when full.
  - `start && len > 0` moves to SCROLL with `pos = 0` and the divider at 0.
  - `start` with `len = 0` is ignored.
- SCROLL:
  - The divider counts 0..DIV-1. At DIV-1 it issues a tick and wraps to 0.
  - On a tick, `pos` advances by 1. When `pos = L-1`, it wraps to 0. `L = len + DISPLAY_COUNT`.
  - `wr_en` and `start` are ignored.
  - `stop` moves to IDLE.
- Virtual sequence: `seq[i] = buf[i]` for `i < len`, and 0x20 for `len ≤ i < L`.
- Digit k shows `seq[(pos + DISPLAY_COUNT-1-k) mod L]`. The sum is always < 2L, so the mod is a single conditional subtract of L.
- `pos` width is clog2(MAX_LEN+DISPLAY_COUNT).
- Outputs:
  - In SCROLL, `display_enable` is all ones and `values` is the current window.
  - In IDLE, `display_enable` is all zeros and `values` is all 0x20.
- Priority, highest first: `reset` > `clear` > `stop` > `start` > tick > `wr_en`.
- `clear` in any state sets `len = 0` and `pos = 0`, enters IDLE, and discards a simultaneous write. Buffer contents are not zeroed.
- `stop` coincident with a tick: `pos` does not advance.

## Timing

- Reset values: state IDLE, `len = 0`, `pos = 0`, divider 0, `wr_ready = 1`, `busy = 0`, `values` all 0x20, `display_enable = 0`.
- All outputs are registers, computed from next-state, so every output reflects an accepted event at the first clock edge after it.
- Write: if `wr_en` is sampled at edge n, `len` is updated and `wr_ready` re-evaluated at edge n (visible in cycle n+1). Back-to-back writes sustain one per cycle.
- Start:
  - If `start` is accepted at edge n, then from edge n `busy = 1` and the window shows `pos = 0`.
  - The first tick occurs DIV cycles later, at edge n+DIV.
  - Each subsequent step occurs every DIV cycles.
- Full scroll period: `L × DIV` cycles.
- Stop: if `stop` is accepted at edge n, then from edge n `busy = 0`, outputs are blanked/disabled, and `wr_ready` is restored if `len < MAX_LEN`.
- Reset mid-scroll or mid-write behaves identically to power-on reset.

## Test plan

Bench parameters: `DISPLAY_COUNT=4`, `MAX_LEN=8`, `SOURCE_FREQ=8`, `SCROLL_HZ=2` (DIV=4).

- **Reset:** assert `reset` 2 cycles → `values = 0x20202020`, `display_enable = 0`, `wr_ready = 1`, `busy = 0`.
- **Scroll sequence:** write 0x48, 0x49 ("HI"), pulse `start` → `values = 0x48492020`. Then every 4 cycles `values` steps through:
  - 0x49202020
  - 0x20202020
  - 0x20202048
  - 0x20204849
  - 0x20484920
  - back to 0x48492020 (24 cycles per period).
- **Full buffer:** write 9 chars back-to-back → `wr_ready` falls after the 8th, the 9th is dropped, and `len = 8`. `start` then shows `buf[0..3]`.
- **Ignored starts and stop/tick collision:**
  - `start` with an empty buffer → stays IDLE, `busy = 0`.
  - `stop` on the same cycle as a tick → IDLE, and a later `start` resumes at `pos = 0`.
- **Clear priority:** `clear` asserted together with `wr_en` and `start` during SCROLL → IDLE, `len = 0`, write discarded, outputs blanked next cycle.
- **Reset mid-scroll:** assert `reset` at `pos = 3` → all outputs at reset values. `start` immediately after is ignored because `len = 0`.
